// File: rtl/parity_share_ctrl.sv
// Round-robin shared parity engine: folds the granted word CHUNK bits per cycle and
// answers over a valid/ready channel. Define PARITY_ERR_CNT_EN for the error counter.
`timescale 1ns/1ps
module parity_share_ctrl #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 64,
  parameter int CHUNK  = 16
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_exp,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_parity,
  output logic                     rsp_err,
`ifdef PARITY_ERR_CNT_EN
  output logic [15:0]              err_count,
`endif
  output logic [1:0]               state_dbg
);

  localparam int IDW = $clog2(NREQ);
  localparam int K   = DATA_W / CHUNK;
  localparam int BW  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_CALC = 2'd2, S_DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              exp_q, exp_d;
  logic              acc_q, acc_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic              par_q, par_d;
  logic              err_q, err_d;
  logic [IDW-1:0]    pick;
  logic              chunk_par;
  logic              fold;

  // First requester at or above p, wrapping past NREQ-1.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] res;
    logic           found;
    int             idx;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(p) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && r[idx]) begin
        res   = IDW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign pick      = rr_pick(req, ptr_q);
  assign chunk_par = ^word_q[int'(beat_q)*CHUNK +: CHUNK];
  assign fold      = acc_q ^ chunk_par;

  // Handshake valid/ready: a response transfers on a cycle where rsp_valid && rsp_ready;
  // rsp_id/rsp_parity/rsp_err hold steady while rsp_valid is high and unaccepted.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    word_d   = word_q;
    exp_d    = exp_q;
    acc_d    = acc_q;
    beat_d   = beat_q;
    rsp_id_d = rsp_id_q;
    par_d    = par_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          sel_d   = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        word_d  = req_data[int'(sel_q)*DATA_W +: DATA_W];
        exp_d   = req_exp[sel_q];
        acc_d   = 1'b0;
        beat_d  = '0;
        ptr_d   = (int'(sel_q) == NREQ - 1) ? '0 : sel_q + 1'b1;
        state_d = S_CALC;
      end
      S_CALC: begin
        acc_d  = fold;
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(K - 1)) begin
          par_d    = fold;
          err_d    = fold != exp_q;
          rsp_id_d = sel_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // Arbitration happens in the handshake cycle so back-to-back requests cost
        // K+2 cycles each; the new gnt still appears only in the following cycle.
        if (rsp_ready) begin
          if (|req) begin
            sel_d   = pick;
            state_d = S_GRANT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      word_q   <= '0;
      exp_q    <= 1'b0;
      acc_q    <= 1'b0;
      beat_q   <= '0;
      rsp_id_q <= '0;
      par_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      word_q   <= word_d;
      exp_q    <= exp_d;
      acc_q    <= acc_d;
      beat_q   <= beat_d;
      rsp_id_q <= rsp_id_d;
      par_q    <= par_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == S_GRANT) gnt[sel_q] = 1'b1;
  end

  assign busy       = state_q != S_IDLE;
  assign rsp_valid  = state_q == S_DONE;
  assign rsp_id     = rsp_id_q;
  assign rsp_parity = par_q;
  assign rsp_err    = err_q;
  assign state_dbg  = state_q;

`ifdef PARITY_ERR_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_DONE && rsp_ready && err_q && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!resetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`endif

endmodule
